// File: rtl/reg_req_initiator_if.sv
// Handshake bundle for reg_req_initiator: host command/response ports and the regreq bus.
// master = initiator view, slave = host/responder view.
interface reg_req_initiator_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        cmd_rd64;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_wr;
   logic [63:0] rsp_rdata;
   logic        regreq_tvalid;
   logic [31:0] regreq_tdata;
   logic [32:0] regreq_tuser;
   logic [31:0] regreq_rdt;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_rd64, rsp_ready, regreq_rdt,
      output cmd_ready, rsp_valid, rsp_wr, rsp_rdata, regreq_tvalid, regreq_tdata, regreq_tuser
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_rd64, rsp_ready, regreq_rdt,
      input  cmd_ready, rsp_valid, rsp_wr, rsp_rdata, regreq_tvalid, regreq_tdata, regreq_tuser
   );
endinterface

// File: rtl/reg_req_initiator.sv
// Register-request initiator: one host command -> one single-cycle regreq strobe -> one response.
// Optional 64-bit pair reads are enabled with `define REG_REQ_INIT_RD64_EN.
module reg_req_initiator #(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned ADDR_W = 16
) (
   input logic                 user_clk,
   input logic                 reset_n,
   reg_req_initiator_if.master bus
);

`ifdef REG_REQ_INIT_RD64_EN
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ISSUE2, S_WAIT2} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
`endif

   state_t              r_state;
   logic                r_cmd_ready;
   logic                r_tvalid;
   logic                r_wr;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [2:0]          r_cnt;
   logic                r_rsp_valid;
   logic                r_rsp_wr;
   logic [31:0]         r_rdata_lo;
`ifdef REG_REQ_INIT_RD64_EN
   logic                r_rd64;
   logic [31:0]         r_rdata_hi;
`else
   logic                w_unused_rd64;
   assign w_unused_rd64 = bus.cmd_rd64;
`endif

   // tdata/tuser come straight from the latched command; r_wdata is already zeroed for reads.
   always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
         r_tvalid    <= 1'b0;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_wr    <= 1'b0;
         r_rdata_lo  <= '0;
`ifdef REG_REQ_INIT_RD64_EN
         r_rd64      <= 1'b0;
         r_rdata_hi  <= '0;
`endif
      end else begin
         r_tvalid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_wr        <= bus.cmd_wr;
                  r_addr      <= bus.cmd_addr;
                  r_wdata     <= bus.cmd_wr ? bus.cmd_wdata : '0;
                  r_rsp_wr    <= 1'b0;
                  r_rdata_lo  <= '0;
`ifdef REG_REQ_INIT_RD64_EN
                  r_rd64      <= bus.cmd_rd64 & ~bus.cmd_wr;
                  r_rdata_hi  <= '0;
`endif
                  r_tvalid    <= 1'b1;
                  r_state     <= S_ISSUE;
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (r_wr) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_wr    <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt   <= 3'(RD_LAT);
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  r_rdata_lo <= bus.regreq_rdt;
`ifdef REG_REQ_INIT_RD64_EN
                  if (r_rd64) begin
                     r_addr   <= r_addr + 16'd4;
                     r_tvalid <= 1'b1;
                     r_state  <= S_ISSUE2;
                  end else begin
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_RESP;
                  end
`else
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
`endif
               end
            end
`ifdef REG_REQ_INIT_RD64_EN
            S_ISSUE2: begin
               r_cnt   <= 3'(RD_LAT);
               r_state <= S_WAIT2;
            end
            S_WAIT2: begin
               r_cnt <= r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  r_rdata_hi  <= bus.regreq_rdt;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
`endif
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready     = r_cmd_ready;
   assign bus.regreq_tvalid = r_tvalid;
   assign bus.regreq_tdata  = r_wdata;
   assign bus.regreq_tuser  = {r_wr, 16'h0000, r_addr};
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_wr        = r_rsp_wr;
`ifdef REG_REQ_INIT_RD64_EN
   assign bus.rsp_rdata     = {r_rdata_hi, r_rdata_lo};
`else
   assign bus.rsp_rdata     = {32'h0000_0000, r_rdata_lo};
`endif

endmodule

// File: tb/tb_reg_req_initiator.sv
// Bench for reg_req_initiator: two instances (RD_LAT 1 and 3) checked every cycle against a
// transaction-timeline model, plus directed literal checks. Honours REG_REQ_INIT_RD64_EN.
module tb_reg_req_initiator;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic user_clk;
   logic reset_n;

   logic        cmd_valid [2];
   logic        cmd_wr    [2];
   logic        cmd_rd64  [2];
   logic        rsp_ready [2];
   logic [15:0] cmd_addr  [2];
   logic [31:0] cmd_wdata [2];
   logic [31:0] rdt       [2];

   logic        o_cmd_ready [2];
   logic        o_rsp_valid [2];
   logic        o_rsp_wr    [2];
   logic        o_tvalid    [2];
   logic [63:0] o_rsp_rdata [2];
   logic [31:0] o_tdata     [2];
   logic [32:0] o_tuser     [2];

   int n_tests;
   int n_fail;

   reg_req_initiator_if bus0 ();
   reg_req_initiator_if bus1 ();

   reg_req_initiator #(.RD_LAT(LAT0), .ADDR_W(16)) u_dut0 (.user_clk(user_clk), .reset_n(reset_n), .bus(bus0));
   reg_req_initiator #(.RD_LAT(LAT1), .ADDR_W(16)) u_dut1 (.user_clk(user_clk), .reset_n(reset_n), .bus(bus1));

   assign bus0.cmd_valid  = cmd_valid[0];  assign bus1.cmd_valid  = cmd_valid[1];
   assign bus0.cmd_wr     = cmd_wr[0];     assign bus1.cmd_wr     = cmd_wr[1];
   assign bus0.cmd_rd64   = cmd_rd64[0];   assign bus1.cmd_rd64   = cmd_rd64[1];
   assign bus0.cmd_addr   = cmd_addr[0];   assign bus1.cmd_addr   = cmd_addr[1];
   assign bus0.cmd_wdata  = cmd_wdata[0];  assign bus1.cmd_wdata  = cmd_wdata[1];
   assign bus0.rsp_ready  = rsp_ready[0];  assign bus1.rsp_ready  = rsp_ready[1];
   assign bus0.regreq_rdt = rdt[0];        assign bus1.regreq_rdt = rdt[1];

   assign o_cmd_ready[0] = bus0.cmd_ready;     assign o_cmd_ready[1] = bus1.cmd_ready;
   assign o_rsp_valid[0] = bus0.rsp_valid;     assign o_rsp_valid[1] = bus1.rsp_valid;
   assign o_rsp_wr[0]    = bus0.rsp_wr;        assign o_rsp_wr[1]    = bus1.rsp_wr;
   assign o_rsp_rdata[0] = bus0.rsp_rdata;     assign o_rsp_rdata[1] = bus1.rsp_rdata;
   assign o_tvalid[0]    = bus0.regreq_tvalid; assign o_tvalid[1]    = bus1.regreq_tvalid;
   assign o_tdata[0]     = bus0.regreq_tdata;  assign o_tdata[1]     = bus1.regreq_tdata;
   assign o_tuser[0]     = bus0.regreq_tuser;  assign o_tuser[1]     = bus1.regreq_tuser;

   initial begin
      user_clk = 1'b0;
      forever #5 user_clk = ~user_clk;
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? LAT0 : LAT1;
   endfunction

   function automatic logic [31:0] mem_of(input logic [15:0] a);
      case (a)
         16'h0280: return 32'hDEADBEEF;
         16'h0300: return 32'hCAFEF00D;
         16'h0400: return 32'h0BADC0DE;
         16'hFFFC: return 32'h11111111;
         16'h0000: return 32'h22222222;
         default:  return {a ^ 16'h5A5A, ~a};
      endcase
   endfunction

   function automatic logic [31:0] noise_of(input int m);
      if (m == 0) return 32'h0;
      if (m == 1) return 32'hFFFF_FFFF;
      return $urandom;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   // Responder: returns mem_of(addr) resp_delay cycles after each strobe, noise otherwise.
   int          pend_cnt   [2];
   int          resp_delay [2];
   int          noise_mode [2];
   int          tv_count   [2];
   logic [31:0] pend_val   [2];
   logic [32:0] last_tuser [2];
   logic [31:0] last_tdata [2];

   always @(negedge user_clk) begin : resp_mon
      for (int d = 0; d < 2; d++) begin
         if (reset_n && o_tvalid[d]) begin
            pend_cnt[d]   = resp_delay[d];
            pend_val[d]   = mem_of(o_tuser[d][15:0]);
            last_tuser[d] = o_tuser[d];
            last_tdata[d] = o_tdata[d];
            tv_count[d]++;
         end
      end
   end

   always @(posedge user_clk) begin : resp_drv
      #1;
      for (int d = 0; d < 2; d++) begin
         if (pend_cnt[d] == 1) begin
            rdt[d]      = pend_val[d];
            pend_cnt[d] = 0;
         end else begin
            rdt[d] = noise_of(noise_mode[d]);
            if (pend_cnt[d] > 1) pend_cnt[d]--;
         end
      end
   end

   // Model: a transaction accepted in cycle H is described by its age (cycles since H).
   bit          m_busy  [2];
   bit          m_rdy   [2];
   bit          m_wr    [2];
   bit          m_rd64  [2];
   int          m_age   [2];
   logic [15:0] m_addr  [2];
   logic [31:0] m_wdata [2];
   logic [63:0] m_data  [2];

   always @(negedge user_clk) begin : cmp
      int L, a, ra;
      bit tv_e, rv_e;
      logic [15:0] a2;
      for (int d = 0; d < 2; d++) begin
         L = lat_of(d);
         if (!reset_n) begin
            check("rst_cmd_ready", 64'(o_cmd_ready[d]), 64'(0));
            check("rst_tvalid",    64'(o_tvalid[d]),    64'(0));
            check("rst_tuser",     64'(o_tuser[d]),     64'(0));
            check("rst_tdata",     64'(o_tdata[d]),     64'(0));
            check("rst_rsp_valid", 64'(o_rsp_valid[d]), 64'(0));
            check("rst_rsp_wr",    64'(o_rsp_wr[d]),    64'(0));
            check("rst_rsp_rdata", o_rsp_rdata[d],      64'(0));
            m_busy[d] = 1'b0;
            m_rdy[d]  = 1'b0;
         end else begin
            a    = m_age[d];
            ra   = m_wr[d] ? 2 : (m_rd64[d] ? 2 * L + 3 : L + 2);
            tv_e = m_busy[d] && (a == 1 || (m_rd64[d] && a == L + 2));
            rv_e = m_busy[d] && (a >= ra);
            a2   = (a == 1) ? m_addr[d] : m_addr[d] + 16'd4;
            check("cmd_ready", 64'(o_cmd_ready[d]), 64'(!m_busy[d] && m_rdy[d]));
            check("tvalid",    64'(o_tvalid[d]),    64'(tv_e));
            if (tv_e) begin
               check("tuser", 64'(o_tuser[d]), 64'({m_wr[d], 16'h0000, a2}));
               check("tdata", 64'(o_tdata[d]), 64'(m_wr[d] ? m_wdata[d] : 32'h0));
            end
            check("rsp_valid", 64'(o_rsp_valid[d]), 64'(rv_e));
            if (rv_e) begin
               check("rsp_wr",    64'(o_rsp_wr[d]), 64'(m_wr[d]));
               check("rsp_rdata", o_rsp_rdata[d],   m_data[d]);
            end
            if (!m_busy[d]) begin
               if (m_rdy[d] && cmd_valid[d]) begin
                  m_busy[d]  = 1'b1;
                  m_age[d]   = 1;
                  m_wr[d]    = cmd_wr[d];
                  m_addr[d]  = cmd_addr[d];
                  m_wdata[d] = cmd_wdata[d];
                  m_data[d]  = '0;
`ifdef REG_REQ_INIT_RD64_EN
                  m_rd64[d]  = cmd_rd64[d] && !cmd_wr[d];
`else
                  m_rd64[d]  = 1'b0;
`endif
               end
               m_rdy[d] = 1'b1;
            end else begin
               if (!m_wr[d] && a == L + 1)         m_data[d][31:0]  = rdt[d];
               if (m_rd64[d] && a == 2 * L + 2)    m_data[d][63:32] = rdt[d];
               if (rv_e && rsp_ready[d]) m_busy[d] = 1'b0;
               else                      m_age[d]  = a + 1;
            end
         end
      end
   end

   task automatic do_cmd(input int d, input logic wr, input logic [15:0] addr,
                         input logic [31:0] wd, input logic rd64);
      bit ok;
      ok           = 1'b0;
      cmd_wr[d]    = wr;
      cmd_addr[d]  = addr;
      cmd_wdata[d] = wd;
      cmd_rd64[d]  = rd64;
      cmd_valid[d] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge user_clk);
         if (o_cmd_ready[d]) begin
            ok = 1'b1;
            break;
         end
      end
      check("cmd_accept", 64'(ok), 64'(1));
      tick();
      cmd_valid[d] = 1'b0;
   endtask

   task automatic wait_rsp(input int d, input int hold, output logic [63:0] data, output logic wr);
      bit ok;
      ok           = 1'b0;
      data         = '0;
      wr           = 1'b0;
      rsp_ready[d] = 1'b0;
      repeat (hold) tick();
      rsp_ready[d] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge user_clk);
         if (o_rsp_valid[d]) begin
            ok   = 1'b1;
            data = o_rsp_rdata[d];
            wr   = o_rsp_wr[d];
            break;
         end
      end
      check("rsp_arrive", 64'(ok), 64'(1));
      tick();
      rsp_ready[d] = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [63:0] rd;
      logic        rw;
      int          seen;
      n_tests = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         cmd_valid[d] = 1'b0;  cmd_wr[d]    = 1'b0;  cmd_rd64[d]   = 1'b0;
         rsp_ready[d] = 1'b0;  cmd_addr[d]  = '0;    cmd_wdata[d]  = '0;
         rdt[d]       = '0;    pend_cnt[d]  = 0;     resp_delay[d] = lat_of(d);
         noise_mode[d] = 1;    tv_count[d]  = 0;     pend_val[d]   = '0;
         m_busy[d]    = 1'b0;  m_rdy[d]     = 1'b0;  m_age[d]      = 0;
         m_wr[d]      = 1'b0;  m_rd64[d]    = 1'b0;  m_addr[d]     = '0;
         m_wdata[d]   = '0;    m_data[d]    = '0;
      end
      repeat (3) tick();
      check("init_cmd_ready", 64'(o_cmd_ready[0]), 64'(0));
      check("init_rsp_rdata", o_rsp_rdata[0], 64'(0));
      reset_n = 1'b1;
      repeat (2) tick();

      // Write at 0x0238
      tv_count[0] = 0;
      do_cmd(0, 1'b1, 16'h0238, 32'h0000_0005, 1'b0);
      wait_rsp(0, 0, rd, rw);
      check("wr_strobes", 64'(tv_count[0]), 64'(1));
      check("wr_tuser",   64'(last_tuser[0]), 64'h1_0000_0238);
      check("wr_tdata",   64'(last_tdata[0]), 64'h5);
      check("wr_rsp_wr",  64'(rw), 64'(1));
      check("wr_rdata",   rd, 64'(0));

      // Read 0x0280 with all-ones stray data outside the sample cycle
      noise_mode[0] = 1;
      tv_count[0]   = 0;
      do_cmd(0, 1'b0, 16'h0280, 32'h1234_5678, 1'b0);
      wait_rsp(0, 0, rd, rw);
      check("rd_strobes", 64'(tv_count[0]), 64'(1));
      check("rd_tuser",   64'(last_tuser[0]), 64'h0_0000_0280);
      check("rd_tdata",   64'(last_tdata[0]), 64'(0));
      check("rd_rsp_wr",  64'(rw), 64'(0));
      check("rd_rdata",   rd, 64'h0000_0000_DEAD_BEEF);

      // Backpressure with a second command pending
      tv_count[0] = 0;
      do_cmd(0, 1'b0, 16'h0400, 32'h0, 1'b0);
      cmd_wr[0]    = 1'b1;
      cmd_addr[0]  = 16'h0404;
      cmd_wdata[0] = 32'h77;
      cmd_valid[0] = 1'b1;
      rsp_ready[0] = 1'b0;
      repeat (10) tick();
      check("bp_no_issue",  64'(tv_count[0]), 64'(1));
      check("bp_rsp_valid", 64'(o_rsp_valid[0]), 64'(1));
      check("bp_rdata",     o_rsp_rdata[0], 64'h0000_0000_0BAD_C0DE);
      wait_rsp(0, 0, rd, rw);
      check("bp_rdata_hs",  rd, 64'h0000_0000_0BAD_C0DE);
      do_cmd(0, 1'b1, 16'h0404, 32'h77, 1'b0);
      wait_rsp(0, 0, rd, rw);
      check("bp_second_wr", 64'(rw), 64'(1));
      check("bp_strobes",   64'(tv_count[0]), 64'(2));

      // Reset one cycle after the strobe on the RD_LAT=3 instance
      do_cmd(1, 1'b0, 16'h0500, 32'h0, 1'b0);
      tick();
      reset_n = 1'b0;
      #1;
      check("arst_tvalid",    64'(o_tvalid[1]),    64'(0));
      check("arst_tuser",     64'(o_tuser[1]),     64'(0));
      check("arst_rsp_valid", 64'(o_rsp_valid[1]), 64'(0));
      check("arst_cmd_ready", 64'(o_cmd_ready[1]), 64'(0));
      repeat (2) tick();
      reset_n      = 1'b1;
      rsp_ready[1] = 1'b1;
      seen         = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge user_clk);
         if (o_rsp_valid[1]) seen++;
         tick();
      end
      check("arst_no_rsp",   64'(seen), 64'(0));
      check("arst_ready_up", 64'(o_cmd_ready[1]), 64'(1));
      rsp_ready[1] = 1'b0;

      // RD_LAT=3: data on time, then one cycle early with zero elsewhere
      noise_mode[1] = 2;
      resp_delay[1] = 3;
      do_cmd(1, 1'b0, 16'h0300, 32'h0, 1'b0);
      wait_rsp(1, 0, rd, rw);
      check("lat3_rdata", rd, 64'h0000_0000_CAFE_F00D);
      noise_mode[1] = 0;
      resp_delay[1] = 2;
      do_cmd(1, 1'b0, 16'h0300, 32'h0, 1'b0);
      wait_rsp(1, 0, rd, rw);
      check("lat3_early", rd, 64'(0));
      resp_delay[1] = 3;

      // 64-bit pair read wrapping at the top of the address space
      noise_mode[0] = 2;
      tv_count[0]   = 0;
      do_cmd(0, 1'b0, 16'hFFFC, 32'h0, 1'b1);
      wait_rsp(0, 1, rd, rw);
`ifdef REG_REQ_INIT_RD64_EN
      check("rd64_rdata",   rd, 64'h2222_2222_1111_1111);
      check("rd64_strobes", 64'(tv_count[0]), 64'(2));
      check("rd64_addr2",   64'(last_tuser[0]), 64'h0_0000_0000);
`else
      check("rd64_rdata",   rd, 64'h0000_0000_1111_1111);
      check("rd64_strobes", 64'(tv_count[0]), 64'(1));
      check("rd64_addr1",   64'(last_tuser[0]), 64'h0_0000_FFFC);
`endif

      // Randomized traffic on both instances
      for (int d = 0; d < 2; d++) begin
         noise_mode[d] = 2;
         resp_delay[d] = lat_of(d);
         for (int n = 0; n < 40; n++) begin
            do_cmd(d, 1'($urandom_range(0, 1)), 16'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
            wait_rsp(d, int'($urandom_range(0, 3)), rd, rw);
            repeat ($urandom_range(0, 2)) tick();
         end
      end

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_req_initiator.md
Name: reg_req_initiator

Overview:
- Initiator end of the register-request bus (regreq_tvalid/tdata/tuser, regreq_rdt) that feeds the per-block register responders, e.g. the performance-counter block.
- Accepts single register commands from a host-side valid/ready command port and issues exactly one single-cycle request per command on regreq.
- For reads, samples the OR-combined regreq_rdt at a fixed latency and returns the data on a valid/ready response port. Writes also get a completion response.

Parameters:
- RD_LAT, 1, cycles from the request cycle to the regreq_rdt sample cycle; legal range 1..4.
- ADDR_W, 16, command address width. Maps onto regreq_tuser[15:0] and is fixed at 16.

Ports:
- user_clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both 1.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  16  byte address.
- cmd_wdata  in  32  write data.
- cmd_rd64  in  1  64-bit read pair. Only used under the optional feature; otherwise ignored.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_wr  out  1  response is a write completion.
- rsp_rdata  out  64  read data. Bits [63:32] are zero except for a 64-bit pair read.
- regreq_tvalid  out  1  request strobe, one cycle wide.
- regreq_tdata  out  32  write data; 0 on reads.
- regreq_tuser  out  33  bit [32] = write, [31:16] = 0, [15:0] = address.
- regreq_rdt  in  32  OR of all responder read data; responders drive 0 when not addressed.

Behaviour:
- Reset values: cmd_ready = 0, rsp_valid = 0, rsp_wr = 0, rsp_rdata = 0, regreq_tvalid = 0, regreq_tdata = 0, regreq_tuser = 0. FSM goes to IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1 only in IDLE; it is a registered output.
  - On handshake, latch cmd_wr, cmd_addr, cmd_wdata, cmd_rd64, then go to ISSUE.
- ISSUE (cycle T):
  - regreq_tvalid = 1 for exactly this cycle, with tuser and tdata from the latched command.
  - Write: go to RESP with rsp_wr = 1 and rsp_rdata = 0.
  - Read: go to WAIT with a latency counter = RD_LAT.
- WAIT:
  - Decrement the counter every cycle.
  - In cycle T + RD_LAT, capture regreq_rdt into rsp_rdata[31:0], then go to RESP.
  - regreq_tvalid = 0 in every cycle outside ISSUE.
- RESP:
  - rsp_valid = 1, with rsp_rdata and rsp_wr held stable until rsp_ready.
  - On handshake, rsp_valid drops and the FSM returns to IDLE.
- Only one transaction is outstanding at a time; there is no pipelining.
- Command-to-request latency: regreq_tvalid is asserted 1 cycle after the cmd handshake.
- Read latency: rsp_valid is asserted RD_LAT + 1 cycles after tvalid.
- Minimum back-to-back spacing is therefore 3 cycles for a write and RD_LAT + 3 cycles for a read.
- regreq_rdt is ignored in every cycle except the sample cycle, so nonzero stray data never reaches rsp_rdata.
- rsp_ready held high in RESP completes the transaction in a single cycle.
- cmd_valid while not in IDLE is not accepted and has no effect.
- Address alignment is not checked; the address passes through unmodified.
- Reset asserted mid-transaction: all state clears immediately and the in-flight request and response are discarded without being reissued. regreq_tvalid drops asynchronously.

Optional Feature:
- Macro: REG_REQ_INIT_RD64_EN.
- Defined: a read with cmd_rd64 = 1 issues two reads.
  - First read at cmd_addr, captured into rsp_rdata[31:0].
  - Second read at cmd_addr + 4 (16-bit wrap), issued in the cycle after the first capture and captured into rsp_rdata[63:32].
  - A single response is returned.
  - Adds states ISSUE2 and WAIT2.
  - A write with cmd_rd64 = 1 behaves as a normal write.
- Not defined: cmd_rd64 is ignored, the ISSUE2 and WAIT2 states do not exist, and rsp_rdata[63:32] is constant 0.

Test Plan:
1. Write: cmd_wr = 1, addr = 0x0238, wdata = 0x05 → exactly one cycle with tvalid = 1, tuser = 0x1_0000_0238, tdata = 0x05. Then rsp_valid with rsp_wr = 1 and rsp_rdata = 0.
2. Read, RD_LAT = 1: responder model returns 0xDEADBEEF one cycle after tvalid for addr 0x0280, and drives 0xFFFFFFFF in all other cycles → rsp_rdata = 0xDEADBEEF; tuser[32] = 0; tdata = 0.
3. Backpressure: hold rsp_ready = 0 for 10 cycles → rsp_valid and rsp_rdata stay stable, cmd_ready = 0, and a pending cmd_valid is not accepted until after the response handshake.
4. Reset mid-WAIT: assert reset_n = 0 one cycle after tvalid → all outputs go to 0 immediately, and after release no response appears and cmd_ready = 1.
5. RD_LAT = 3 sweep: responder returns data 3 cycles after tvalid → the correct word is captured. Repeat with data at 2 cycles → 0 is captured.
6. REG_REQ_INIT_RD64_EN: rd64 at 0xFFFC with data 0x11111111 / 0x22222222 → second request at address 0x0000 and rsp_rdata = 0x22222222_11111111. With the macro undefined → a single read and rsp_rdata[63:32] = 0.
